// File: rtl/spectro_pkg.sv
// Shared spectrogram-path types and constants.
// Used by the FFT output serializer and the input demultiplexer.
package spectro_pkg;

    localparam int DEF_DATA_W   = 12;
    localparam int DEF_NUM_BINS = 8;

    localparam logic [11:0] SYNC_WORD = 12'hA5A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEND,
        ST_GAP
    } fso_state_t;

endpackage

// File: rtl/fft_output_serializer.sv
// Serializes one packed FFT frame into per-bin valid/ready beats.
// Optional leading sync beat when FFT_OUT_SYNC_EN is defined.
module fft_output_serializer
    import spectro_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_BINS   = DEF_NUM_BINS,
    parameter int GAP_CYCLES = 7,
    localparam int IDX_W     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_BINS*DATA_W-1:0] frame_data,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           out_index,
    output logic                       out_last,
    output logic                       out_sync
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic ONE_BIN = (NUM_BINS == 1);

    fso_state_t                 state;
    logic [NUM_BINS*DATA_W-1:0] hold;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           idx_nxt;
    logic [GAP_W-1:0]           gap_cnt;

`ifdef FFT_OUT_SYNC_EN
    logic sync_q;
    assign out_sync = sync_q;
`else
    assign out_sync = 1'b0;
`endif

    assign idx_nxt = idx + IDX_W'(1);

    // Frame capture, beat sequencing and inter-frame gap; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            frame_ready <= 1'b0;
            hold        <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
`ifdef FFT_OUT_SYNC_EN
            sync_q      <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    frame_ready <= 1'b1;
                    if (frame_valid && frame_ready) begin
                        hold        <= frame_data;
                        frame_ready <= 1'b0;
                        idx         <= '0;
                        out_valid   <= 1'b1;
                        out_index   <= '0;
`ifdef FFT_OUT_SYNC_EN
                        state       <= ST_SYNC;
                        out_data    <= DATA_W'(SYNC_WORD);
                        out_last    <= 1'b0;
                        sync_q      <= 1'b1;
`else
                        state       <= ST_SEND;
                        out_data    <= frame_data[DATA_W-1:0];
                        out_last    <= ONE_BIN;
`endif
                    end
                end
`ifdef FFT_OUT_SYNC_EN
                ST_SYNC: begin
                    if (out_ready) begin
                        state    <= ST_SEND;
                        out_data <= hold[DATA_W-1:0];
                        out_last <= ONE_BIN;
                        sync_q   <= 1'b0;
                    end
                end
`endif
                ST_SEND: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state   <= ST_GAP;
                                gap_cnt <= GAP_LOAD;
                            end else begin
                                state       <= ST_IDLE;
                                frame_ready <= 1'b1;
                            end
                        end else begin
                            idx       <= idx_nxt;
                            out_index <= idx_nxt;
                            out_data  <= hold[DATA_W*int'(idx_nxt) +: DATA_W];
                            out_last  <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state       <= ST_IDLE;
                        frame_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Randomized check of fft_output_serializer against a beat-queue model.
// Runs a GAP_CYCLES=7 instance and a GAP_CYCLES=0 instance side by side.
module tb_fft_output_serializer;
    import spectro_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] frame_data = '0;
    logic        frame_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic [1:0]  fr, ov, ol, os;
    logic [11:0] od [2];
    logic [2:0]  oi [2];

    int total = 0;
    int bad = 0;

    // model state per instance: pending beat list, ready flag, gap countdown
    logic [11:0] ed [2][9];
    int          ei [2][9];
    logic        el [2][9];
    logic        es [2][9];
    int          pos [2];
    int          n [2];
    logic        mrdy [2];
    int          gl [2];
    int          gapv [2];

    always #5 clk = ~clk;

    fft_output_serializer #(.GAP_CYCLES(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(fr[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_index(oi[0]), .out_last(ol[0]), .out_sync(os[0])
    );

    fft_output_serializer #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(fr[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .out_index(oi[1]), .out_last(ol[1]), .out_sync(os[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one model by one clock edge using the inputs present before it
    task automatic step(input int m);
        int k;
        if (!rst_n) begin
            pos[m] = 0; n[m] = 0; mrdy[m] = 1'b0; gl[m] = 1;
        end else if (mrdy[m] && frame_valid) begin
            k = 0;
`ifdef FFT_OUT_SYNC_EN
            ed[m][0] = SYNC_WORD; ei[m][0] = 0; el[m][0] = 0; es[m][0] = 1;
            k = 1;
`endif
            for (int b = 0; b < 8; b++) begin
                ed[m][k] = frame_data[b*12 +: 12];
                ei[m][k] = b;
                el[m][k] = (b == 7);
                es[m][k] = 1'b0;
                k++;
            end
            n[m] = k; pos[m] = 0; mrdy[m] = 1'b0;
        end else if (pos[m] < n[m]) begin
            if (out_ready) begin
                pos[m]++;
                if (pos[m] == n[m]) begin
                    if (gapv[m] > 0) gl[m] = gapv[m];
                    else mrdy[m] = 1'b1;
                end
            end
        end else if (gl[m] > 0) begin
            gl[m]--;
            if (gl[m] == 0) mrdy[m] = 1'b1;
        end
    endtask

    task automatic compare(input int m);
        logic v;
        string p;
        p = (m == 0) ? "g7" : "g0";
        v = (pos[m] < n[m]);
        chk({p, "_ready"}, 32'(fr[m]), 32'(mrdy[m]));
        chk({p, "_valid"}, 32'(ov[m]), 32'(v));
        chk({p, "_data"},  32'(od[m]), v ? 32'(ed[m][pos[m]]) : 0);
        chk({p, "_index"}, 32'(oi[m]), v ? 32'(ei[m][pos[m]]) : 0);
        chk({p, "_last"},  32'(ol[m]), v ? 32'(el[m][pos[m]]) : 0);
        chk({p, "_sync"},  32'(os[m]), v ? 32'(es[m][pos[m]]) : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        step(0);
        step(1);
        #1;
        compare(0);
        compare(1);
    endtask

    function automatic logic [95:0] ramp();
        logic [95:0] f;
        for (int b = 0; b < 8; b++) f[b*12 +: 12] = 12'(b + 1);
        return f;
    endfunction

    function automatic logic [95:0] rnd_frame();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        int stalls;
        int budget;
        gapv[0] = 7; gapv[1] = 0;
        for (int m = 0; m < 2; m++) begin
            pos[m] = 0; n[m] = 0; mrdy[m] = 1'b0; gl[m] = 1;
        end
        #1;
        for (int m = 0; m < 2; m++) compare(m);
        repeat (2) cycle();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // ramp frame, full throughput; new data kept valid during the frame
        @(negedge clk);
        frame_data = ramp();
        frame_valid = 1'b1;
        out_ready = 1'b1;
        cycle();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            frame_data = rnd_frame();
            cycle();
        end

        // stall three cycles on bin 2 of a ramp frame
        @(negedge clk);
        frame_valid = 1'b0;
        budget = 0;
        while (!(mrdy[0] && mrdy[1]) && budget < 40) begin
            cycle();
            budget++;
        end
        chk("idle_wait", 32'(mrdy[0] && mrdy[1]), 1);
        @(negedge clk);
        frame_data = ramp();
        frame_valid = 1'b1;
        cycle();
        @(negedge clk);
        frame_valid = 1'b0;
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            if (pos[0] < n[0] && ei[0][pos[0]] == 2 && !es[0][pos[0]] &&
                stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            cycle();
            @(negedge clk);
        end
        chk("stall_seen", 32'(stalls), 3);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            frame_valid = ($urandom_range(0, 3) != 0);
            frame_data = rnd_frame();
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
            @(negedge clk);
        end

        // reset while the gapped instance is on bin 4
        out_ready = 1'b1;
        frame_valid = 1'b1;
        frame_data = rnd_frame();
        budget = 0;
        while (!(pos[0] < n[0] && ei[0][pos[0]] == 4 && !es[0][pos[0]]) &&
               budget < 60) begin
            cycle();
            @(negedge clk);
            budget++;
        end
        chk("bin4_reached", 32'(budget < 60), 1);
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_valid", 32'(ov[m]), 0);
            chk("rst_data", 32'(od[m]), 0);
            chk("rst_index", 32'(oi[m]), 0);
            chk("rst_ready", 32'(fr[m]), 0);
        end
        repeat (2) cycle();
        @(negedge clk);
        rst_n = 1'b1;
        frame_valid = 1'b0;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_output_serializer.md
FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

Interface
REQ-001 Parameter DATA_W, default 12: width of one bin sample.
REQ-002 Parameter NUM_BINS, default 8: bins per frame; the index width is clog2(NUM_BINS).
REQ-003 Parameter GAP_CYCLES, default 7: number of idle cycles after each frame before the next frame is accepted.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 frame_data  in  NUM_BINS*DATA_W  packed FFT frame; bin k occupies bits [k*DATA_W +: DATA_W].
REQ-007 frame_valid  in  1  frame_data holds a complete frame.
REQ-008 frame_ready  out  1  block can accept a frame; registered.
REQ-009 out_data  out  DATA_W  current serial word.
REQ-010 out_valid  out  1  out_data is valid.
REQ-011 out_ready  in  1  downstream accepts the word.
REQ-012 out_index  out  clog2(NUM_BINS)  bin number of out_data.
REQ-013 out_last  out  1  out_data is the final bin of the frame.
REQ-014 out_sync  out  1  out_data is the frame sync word.

Function
REQ-015 FSM states: IDLE, SYNC, SEND, GAP; the state register is the only source of frame_ready and out_valid.
REQ-016 IDLE: frame_ready=1, out_valid=0.
- A frame transfers when frame_valid && frame_ready.
- On transfer, all NUM_BINS words are captured into the holding registers and the FSM goes to SYNC (macro defined) or SEND (macro undefined).
REQ-017 frame_ready SHALL be 0 in SYNC, SEND and GAP; frame_valid is ignored there, and frame_data changes there have no effect.
REQ-018 Beat rules:
- A beat completes on out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_data, out_index, out_last and out_sync SHALL hold stable.
- out_valid never drops without a completed beat.
REQ-019 SEND:
- out_valid=1, out_data=bin[idx], out_index=idx, out_last=(idx==NUM_BINS-1).
- idx starts at 0 and increments per completed beat.
- A completed beat with out_last=1 goes to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
REQ-020 Latency: frame accepted at edge N -> first word (sync or bin 0) valid after edge N; with out_ready held 1, the frame's last bin completes at edge N+NUM_BINS (+1 with sync).
REQ-021 GAP:
- out_valid=0.
- Counter loads GAP_CYCLES-1 on entry and decrements each cycle.
- On reaching 0 the FSM goes to IDLE, so frame_ready rises exactly GAP_CYCLES cycles after the last beat.
REQ-022 out_data passes captured values unmodified; no arithmetic or truncation.
REQ-023 When out_valid=0, out_data, out_index, out_last and out_sync SHALL be 0.

Reset
REQ-024 While rst_n=0:
- State is IDLE with frame_ready=0, out_valid=0, out_data=0, out_index=0, out_last=0, out_sync=0.
- Holding registers, idx and gap counter are 0.
REQ-025 Reset mid-frame abandons the frame with no further beats; frame_ready rises on the first posedge after rst_n deasserts.

Configuration
REQ-026 Macro FFT_OUT_SYNC_EN, when defined:
- SYNC state emits one beat with out_valid=1, out_sync=1, out_data=SYNC_WORD, out_index=0, out_last=0.
- The FSM advances to SEND only when that beat completes.
REQ-027 Macro undefined: SYNC state is unreachable, out_sync is tied 0, and frames start directly in SEND.

Structure
REQ-028 Shared package spectro_pkg SHALL hold the state enum typedef, SYNC_WORD (12'hA5A), and default DATA_W/NUM_BINS constants common with the input demultiplexer.
REQ-029 No sub-module is required; FSM, holding registers and gap counter live in one module.

Verification
REQ-030 Bins 0x001..0x008, out_ready=1, macro off -> out_data 0x001..0x008 on 8 consecutive cycles, out_last only on 0x008, then 7 cycles frame_ready=0, then frame_ready=1.
REQ-031 Same frame, out_ready low for 3 cycles on bin 2 -> out_data=0x003 and out_index=2 held stable for all stalled cycles, no bin skipped or repeated.
REQ-032 Macro on -> first beat 0xA5A with out_sync=1; 0x001 follows; 9 beats total.
REQ-033 frame_valid held high with new data during SEND -> ignored; the second frame is accepted only at the first IDLE cycle and its words appear intact.
REQ-034 rst_n pulsed low at bin 4 -> all outputs 0 immediately; no beats afterwards; frame_ready=1 one edge after release.
REQ-035 GAP_CYCLES=0, back-to-back frames -> frame_ready high on the cycle after the last beat.
